// File: rtl/tcam_lut_arb_sm.sv
// Multi-port ternary CAM + LUT with round-robin lookup arbitration,
// saturating per-entry hit counters and a register-side read/write port.
module tcam_lut_arb_sm #(
  parameter int CMP_WIDTH      = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int LUT_DEPTH      = 16,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int NUM_PORTS      = 2,
  parameter int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int CNT_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           lookup_req,
  input  logic [NUM_PORTS*CMP_WIDTH-1:0] lookup_cmp_data,
  output logic [NUM_PORTS-1:0]           lookup_gnt,
  output logic                           lookup_ack,
  output logic [PORT_BITS-1:0]           lookup_port,
  output logic                           lookup_hit,
  output logic [LUT_DEPTH_BITS-1:0]      lookup_index,
  output logic [DATA_WIDTH-1:0]          lookup_data,
  input  logic                           rd_req,
  input  logic [LUT_DEPTH_BITS-1:0]      rd_addr,
  output logic                           rd_ack,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [CMP_WIDTH-1:0]           rd_cmp_data,
  output logic [CMP_WIDTH-1:0]           rd_cmp_dmask,
  output logic                           rd_valid,
  output logic [CNT_WIDTH-1:0]           rd_hit_count,
  input  logic                           wr_req,
  input  logic [LUT_DEPTH_BITS-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [CMP_WIDTH-1:0]           wr_cmp_data,
  input  logic [CMP_WIDTH-1:0]           wr_cmp_dmask,
  input  logic                           wr_valid,
  output logic                           wr_ack,
  output logic                           busy
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX =
    LUT_DEPTH_BITS'(LUT_DEPTH - 1);

  state_t                    state, state_nxt;
  logic [LUT_DEPTH_BITS-1:0] reset_count;

  logic [LUT_DEPTH-1:0]      ent_valid;
  logic [CMP_WIDTH-1:0]      ent_cmp   [LUT_DEPTH];
  logic [CMP_WIDTH-1:0]      ent_dmask [LUT_DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data  [LUT_DEPTH];
  logic [CNT_WIDTH-1:0]      ent_cnt   [LUT_DEPTH];

  logic [PORT_BITS-1:0]      rr, rr_nxt, gnt_id;
  logic [NUM_PORTS-1:0]      gnt;
  logic                      gnt_any, gnt_en;
  logic [CMP_WIDTH-1:0]      key_sel;

  logic                      s1_vld;
  logic [PORT_BITS-1:0]      s1_port;
  logic [CMP_WIDTH-1:0]      s1_key;
  logic [LUT_DEPTH-1:0]      s1_match;

  logic                      s2_vld;
  logic [PORT_BITS-1:0]      s2_port;
  logic [LUT_DEPTH-1:0]      s2_match;
  logic                      s2_hit;
  logic [LUT_DEPTH_BITS-1:0] s2_idx;

  logic                      wr_commit, rd_accept, ready;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (reset_count == LAST_IDX) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)              reset_count <= '0;
    else if (state == INIT) reset_count <= reset_count + 1'b1;
  end

  assign busy  = (state == INIT);
  assign ready = (state == READY) && !reset;

  // A write waits for the match/encode stages to drain so it never
  // races a lookup already in flight.
  assign wr_commit = ready && wr_req && !s1_vld && !s2_vld;
  assign wr_ack    = wr_commit;
  assign rd_accept = ready && rd_req && !wr_commit && !rd_ack;
  assign gnt_en    = ready && !wr_req;

  always_comb begin
    int p;
    p       = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    key_sel = '0;
    if (gnt_en) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        p = (int'(rr) + k) % NUM_PORTS;
        if (!gnt_any && lookup_req[p]) begin
          gnt_any = 1'b1;
          gnt[p]  = 1'b1;
          gnt_id  = PORT_BITS'(p);
          key_sel = lookup_cmp_data[p*CMP_WIDTH +: CMP_WIDTH];
        end
      end
    end
    rr_nxt = (int'(gnt_id) == NUM_PORTS - 1) ? '0 : gnt_id + 1'b1;
  end

  assign lookup_gnt = gnt;

  always_comb begin
    for (int e = 0; e < LUT_DEPTH; e++)
      s1_match[e] = ent_valid[e] &&
        (((s1_key ^ ent_cmp[e]) & ~ent_dmask[e]) == '0);
  end

  always_comb begin
    s2_hit = |s2_match;
    s2_idx = '0;
    for (int e = LUT_DEPTH - 1; e >= 0; e--)
      if (s2_match[e]) s2_idx = LUT_DEPTH_BITS'(e);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr           <= '0;
      s1_vld       <= 1'b0;
      s1_port      <= '0;
      s1_key       <= '0;
      s2_vld       <= 1'b0;
      s2_port      <= '0;
      s2_match     <= '0;
      lookup_ack   <= 1'b0;
      lookup_port  <= '0;
      lookup_hit   <= 1'b0;
      lookup_index <= '0;
      lookup_data  <= DEFAULT_DATA;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        rr      <= rr_nxt;
        s1_port <= gnt_id;
        s1_key  <= key_sel;
      end
      s2_vld       <= s1_vld;
      s2_port      <= s1_port;
      s2_match     <= s1_match;
      lookup_ack   <= s2_vld;
      lookup_port  <= s2_vld ? s2_port : '0;
      lookup_hit   <= s2_vld && s2_hit;
      lookup_index <= (s2_vld && s2_hit) ? s2_idx : '0;
      lookup_data  <= (s2_vld && s2_hit) ? ent_data[s2_idx]
                                         : DEFAULT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      ent_valid[reset_count] <= 1'b0;
      ent_cmp[reset_count]   <= '0;
      ent_dmask[reset_count] <= '0;
      ent_data[reset_count]  <= '0;
    end else if (wr_commit) begin
      ent_valid[wr_addr] <= wr_valid;
      ent_cmp[wr_addr]   <= wr_cmp_data;
      ent_dmask[wr_addr] <= wr_cmp_dmask;
      ent_data[wr_addr]  <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT)
      ent_cnt[reset_count] <= '0;
    else if (wr_commit)
      ent_cnt[wr_addr] <= '0;
    else if (s2_vld && s2_hit && (ent_cnt[s2_idx] != '1))
      ent_cnt[s2_idx] <= ent_cnt[s2_idx] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack       <= 1'b0;
      rd_data      <= '0;
      rd_cmp_data  <= '0;
      rd_cmp_dmask <= '0;
      rd_valid     <= 1'b0;
      rd_hit_count <= '0;
    end else begin
      rd_ack <= rd_accept;
      if (rd_accept) begin
        rd_data      <= ent_data[rd_addr];
        rd_cmp_data  <= ent_cmp[rd_addr];
        rd_cmp_dmask <= ent_dmask[rd_addr];
        rd_valid     <= ent_valid[rd_addr];
        rd_hit_count <= ent_cnt[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_tcam_lut_arb_sm.sv
// Directed bench for tcam_lut_arb_sm: init, match priority, arbitration,
// write drain, read timing, counter saturation and reset mid-lookup.
module tb_tcam_lut_arb_sm;

  localparam logic [7:0] DEF = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lookup_req;
  logic [63:0] lookup_cmp_data;
  logic [1:0]  lookup_gnt;
  logic        lookup_ack;
  logic        lookup_port;
  logic        lookup_hit;
  logic [3:0]  lookup_index;
  logic [7:0]  lookup_data;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic [31:0] rd_cmp_data;
  logic [31:0] rd_cmp_dmask;
  logic        rd_valid;
  logic [3:0]  rd_hit_count;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [31:0] wr_cmp_data;
  logic [31:0] wr_cmp_dmask;
  logic        wr_valid;
  logic        wr_ack;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  tcam_lut_arb_sm #(
    .CMP_WIDTH(32), .DATA_WIDTH(8), .LUT_DEPTH(16),
    .NUM_PORTS(2), .CNT_WIDTH(4), .DEFAULT_DATA(DEF)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_cmp_data(lookup_cmp_data),
    .lookup_gnt(lookup_gnt), .lookup_ack(lookup_ack),
    .lookup_port(lookup_port), .lookup_hit(lookup_hit),
    .lookup_index(lookup_index), .lookup_data(lookup_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_cmp_data(rd_cmp_data),
    .rd_cmp_dmask(rd_cmp_dmask), .rd_valid(rd_valid),
    .rd_hit_count(rd_hit_count),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_cmp_data(wr_cmp_data), .wr_cmp_dmask(wr_cmp_dmask),
    .wr_valid(wr_valid), .wr_ack(wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tally(input string tag, input bit ok,
                       input logic [63:0] o, input logic [63:0] e);
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] c,
                       input logic [31:0] m, input logic [7:0] d,
                       input logic v);
    int n;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = a; wr_cmp_data = c;
    wr_cmp_dmask = m; wr_data = d; wr_valid = v;
    #1;
    n = 0;
    while (!wr_ack && n < 8) begin
      @(negedge clk); #1; n++;
    end
    tally("wr_ack", wr_ack === 1'b1, wr_ack, 1'b1);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic do_rd(input logic [3:0] a, input logic ev,
                       input logic [7:0] ed, input logic [31:0] ec,
                       input logic [31:0] em, input logic [3:0] en);
    int n;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!rd_ack && n < 8);
    tally("rd_latency", n === 1, n, 1);
    tally("rd_valid", rd_valid === ev, rd_valid, ev);
    tally("rd_data", rd_data === ed, rd_data, ed);
    tally("rd_cmp_data", rd_cmp_data === ec, rd_cmp_data, ec);
    tally("rd_cmp_dmask", rd_cmp_dmask === em, rd_cmp_dmask, em);
    tally("rd_hit_count", rd_hit_count === en, rd_hit_count, en);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    tally("rd_ack_pulse", rd_ack === 1'b0, rd_ack, 1'b0);
  endtask

  task automatic lk(input int p, input logic [31:0] key,
                    input logic eh, input logic [3:0] ei,
                    input logic [7:0] ed);
    logic [1:0] eg;
    logic       ep;
    eg = 2'b01 << p;
    ep = (p == 1);
    @(negedge clk);
    lookup_req = 2'b00;
    lookup_req[p] = 1'b1;
    lookup_cmp_data[p*32 +: 32] = key;
    #1;
    tally("lk_gnt", lookup_gnt === eg, lookup_gnt, eg);
    @(negedge clk);
    lookup_req = 2'b00;
    #1;
    tally("lk_ack_t1", lookup_ack === 1'b0, lookup_ack, 1'b0);
    @(negedge clk); #1;
    tally("lk_ack_t2", lookup_ack === 1'b0, lookup_ack, 1'b0);
    @(negedge clk); #1;
    tally("lk_ack_t3", lookup_ack === 1'b1, lookup_ack, 1'b1);
    tally("lk_port", lookup_port === ep, lookup_port, ep);
    tally("lk_hit", lookup_hit === eh, lookup_hit, eh);
    tally("lk_index", lookup_index === ei, lookup_index, ei);
    tally("lk_data", lookup_data === ed, lookup_data, ed);
    @(negedge clk); #1;
    tally("lk_ack_t4", lookup_ack === 1'b0, lookup_ack, 1'b0);
  endtask

  initial begin
    logic [1:0] eg;
    logic       ep;
    reset = 1'b1;
    lookup_req = 2'b00; lookup_cmp_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    wr_cmp_data = '0; wr_cmp_dmask = '0; wr_valid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    tally("rst_busy", busy === 1'b1, busy, 1'b1);
    tally("rst_ack", lookup_ack === 1'b0, lookup_ack, 1'b0);
    tally("rst_data", lookup_data === DEF, lookup_data, DEF);
    tally("rst_rd_ack", rd_ack === 1'b0, rd_ack, 1'b0);
    tally("rst_gnt", lookup_gnt === 2'b00, lookup_gnt, 2'b00);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        reset = 1'b0;
        lookup_req = 2'b01;
      end
      #1;
      tally("init_busy", busy === 1'b1, busy, 1'b1);
      tally("init_gnt", lookup_gnt === 2'b00, lookup_gnt, 2'b00);
    end
    @(negedge clk);
    lookup_req = 2'b00;
    #1;
    tally("ready_busy", busy === 1'b0, busy, 1'b0);
    do_rd(4'd5, 1'b0, 8'h00, 32'h0, 32'h0, 4'd0);

    do_wr(4'd3, 32'h0A000000, 32'h00FFFFFF, 8'h42, 1'b1);
    lk(0, 32'h0A010203, 1'b1, 4'd3, 8'h42);
    lk(0, 32'h0B000000, 1'b0, 4'd0, DEF);

    do_wr(4'd2, 32'h12340000, 32'h0000FFFF, 8'h22, 1'b1);
    do_wr(4'd7, 32'h12345678, 32'h00000000, 8'h77, 1'b1);
    lk(1, 32'h12345678, 1'b1, 4'd2, 8'h22);
    do_wr(4'd2, 32'h12340000, 32'h0000FFFF, 8'h22, 1'b0);
    lk(1, 32'h12345678, 1'b1, 4'd7, 8'h77);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        lookup_req = 2'b11;
        lookup_cmp_data = {32'h12345678, 32'h0A000001};
      end
      if (i == 6) lookup_req = 2'b00;
      #1;
      eg = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      tally("rr_gnt", lookup_gnt === eg, lookup_gnt, eg);
      if (i >= 3 && i < 9) begin
        ep = ((i - 3) % 2 == 1);
        tally("rr_ack", lookup_ack === 1'b1, lookup_ack, 1'b1);
        tally("rr_port", lookup_port === ep, lookup_port, ep);
        tally("rr_index", lookup_index === (ep ? 4'd7 : 4'd3),
              lookup_index, ep ? 4'd7 : 4'd3);
        tally("rr_data", lookup_data === (ep ? 8'h77 : 8'h42),
              lookup_data, ep ? 8'h77 : 8'h42);
      end else if (i == 9) begin
        tally("rr_ack_end", lookup_ack === 1'b0, lookup_ack, 1'b0);
      end
    end

    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          lookup_req = 2'b01;
          lookup_cmp_data[31:0] = 32'h0A000001;
        end
        3: begin
          wr_req = 1'b1; wr_addr = 4'd3; wr_data = 8'h99;
          wr_cmp_data = 32'h0A000000; wr_cmp_dmask = 32'h00FFFFFF;
          wr_valid = 1'b1;
        end
        5: begin rd_req = 1'b1; rd_addr = 4'd3; end
        6: wr_req = 1'b0;
        8: begin lookup_req = 2'b00; rd_req = 1'b0; end
        default: ;
      endcase
      #1;
      eg = (c < 3 || c == 6 || c == 7) ? 2'b01 : 2'b00;
      tally("ws_gnt", lookup_gnt === eg, lookup_gnt, eg);
      tally("ws_wr_ack", wr_ack === (c == 5), wr_ack, (c == 5));
      tally("ws_ack",
            lookup_ack === ((c >= 3 && c <= 5) || c == 9 || c == 10),
            lookup_ack, ((c >= 3 && c <= 5) || c == 9 || c == 10));
      if (c >= 3 && c <= 5)
        tally("ws_old_data", lookup_data === 8'h42, lookup_data, 8'h42);
      if (c == 9 || c == 10)
        tally("ws_new_data", lookup_data === 8'h99, lookup_data, 8'h99);
      if (c == 6 || c == 8)
        tally("ws_rd_ack_lo", rd_ack === 1'b0, rd_ack, 1'b0);
      if (c == 7) begin
        tally("ws_rd_ack", rd_ack === 1'b1, rd_ack, 1'b1);
        tally("ws_rd_data", rd_data === 8'h99, rd_data, 8'h99);
        tally("ws_rd_count", rd_hit_count === 4'd0, rd_hit_count, 4'd0);
      end
    end

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          lookup_req = 2'b10;
          lookup_cmp_data[63:32] = 32'h12345678;
        end
        1: lookup_req = 2'b00;
        2: begin rd_req = 1'b1; rd_addr = 4'd7; end
        4: rd_req = 1'b0;
        default: ;
      endcase
      #1;
      if (c == 0)
        tally("pi_gnt", lookup_gnt === 2'b10, lookup_gnt, 2'b10);
      if (c == 3) begin
        tally("pi_rd_ack", rd_ack === 1'b1, rd_ack, 1'b1);
        tally("pi_rd_count", rd_hit_count === 4'd4, rd_hit_count, 4'd4);
        tally("pi_ack", lookup_ack === 1'b1, lookup_ack, 1'b1);
        tally("pi_index", lookup_index === 4'd7, lookup_index, 4'd7);
      end
    end
    do_rd(4'd7, 1'b1, 8'h77, 32'h12345678, 32'h0, 4'd5);

    do_wr(4'd1, 32'hCAFE0000, 32'h0000FFFF, 8'h11, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        lookup_req = 2'b10;
        lookup_cmp_data[63:32] = 32'hCAFE1234;
      end
      #1;
      tally("sat_gnt", lookup_gnt === 2'b10, lookup_gnt, 2'b10);
    end
    @(negedge clk);
    lookup_req = 2'b00;
    repeat (3) @(negedge clk);
    do_rd(4'd1, 1'b1, 8'h11, 32'hCAFE0000, 32'h0000FFFF, 4'd15);

    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          lookup_req = 2'b01;
          lookup_cmp_data[31:0] = 32'h0A000001;
        end
        1: begin lookup_req = 2'b00; reset = 1'b1; end
        2: reset = 1'b0;
        default: ;
      endcase
      #1;
      if (c == 0)
        tally("mr_gnt", lookup_gnt === 2'b01, lookup_gnt, 2'b01);
      if (c == 2)
        tally("mr_busy", busy === 1'b1, busy, 1'b1);
      if (c >= 2)
        tally("mr_no_ack", lookup_ack === 1'b0, lookup_ack, 1'b0);
    end
    repeat (16) @(negedge clk);
    #1;
    tally("mr_ready", busy === 1'b0, busy, 1'b0);
    do_rd(4'd3, 1'b0, 8'h00, 32'h0, 32'h0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
